// File: rtl/condlogic_pkg.sv
// Shared controller definitions: ARM condition-code encodings and NZCV bit positions.
package condlogic_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/condlogic_condcheck.sv
// Combinational condition evaluator: decides whether the current instruction executes.
module condcheck
  import condlogic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_ge;

  assign w_n  = Flags[FLAG_N];
  assign w_z  = Flags[FLAG_Z];
  assign w_c  = Flags[FLAG_C];
  assign w_v  = Flags[FLAG_V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: CondEx = w_z;
      COND_NE: CondEx = ~w_z;
      COND_CS: CondEx = w_c;
      COND_CC: CondEx = ~w_c;
      COND_MI: CondEx = w_n;
      COND_PL: CondEx = ~w_n;
      COND_VS: CondEx = w_v;
      COND_VC: CondEx = ~w_v;
      COND_HI: CondEx = w_c & ~w_z;
      COND_LS: CondEx = ~w_c | w_z;
      COND_GE: CondEx = w_ge;
      COND_LT: CondEx = ~w_ge;
      COND_GT: CondEx = ~w_z & w_ge;
      COND_LE: CondEx = w_z | ~w_ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution unit: NZCV flag register, condition evaluation and commit-strobe gating.
module condlogic
  import condlogic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic [1:0] r_flags_nz;
  logic [1:0] r_flags_cv;
  logic       r_condex_d;
  logic       w_condex;
  logic [1:0] w_flagwrite;

  assign Flags = {r_flags_nz, r_flags_cv};

  condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (w_condex)
  );

  assign w_flagwrite = FlagW & {2{w_condex}};

  // N,Z and C,V halves load independently so logical ops can leave C,V untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags_nz <= 2'b00;
    end else if (w_flagwrite[1]) begin
      r_flags_nz <= ALUFlags[FLAG_N:FLAG_Z];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags_cv <= 2'b00;
    end else if (w_flagwrite[0]) begin
      r_flags_cv <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_condex_d <= 1'b0;
    end else begin
      r_condex_d <= w_condex;
    end
  end

  // Writes happen in the state after evaluation; fetch (NextPC) is never suppressed
  assign PCWrite  = (PCS & r_condex_d) | NextPC;
  assign RegWrite = RegW & r_condex_d;
  assign MemWrite = MemW & r_condex_d;

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic: cycle-by-cycle reference model plus directed literal checks.
module tb_condlogic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;

  int errors = 0;
  int checks = 0;

  condlogic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ARM pairs conditions, odd encodings are the negation of the even one
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  logic [3:0] m_flags;
  bit         m_cxd;
  bit         m_ok = 1'b0;

  always @(posedge clk) begin
    bit ce;
    ce = m_cond(Cond, m_flags);
    if (reset) begin
      m_flags <= 4'b0000;
      m_cxd   <= 1'b0;
      m_ok    <= 1'b1;
    end else if (m_ok) begin
      m_flags <= {(FlagW[1] && ce) ? ALUFlags[3:2] : m_flags[3:2],
                  (FlagW[0] && ce) ? ALUFlags[1:0] : m_flags[1:0]};
      m_cxd   <= ce;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      checks++;
      if ({PCWrite, RegWrite, MemWrite, Flags} !==
          {((PCS && m_cxd) || NextPC), (RegW && m_cxd), (MemW && m_cxd), m_flags}) begin
        errors++;
        $display("FAIL model t=%0t: got PCW=%b RegW=%b MemW=%b Flags=%b, want PCW=%b RegW=%b MemW=%b Flags=%b",
                 $time, PCWrite, RegWrite, MemWrite, Flags,
                 (PCS && m_cxd) || NextPC, RegW && m_cxd, MemW && m_cxd, m_flags);
      end
    end
  end

  task automatic lit(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Advance one clock edge, then return just after it so inputs can be changed
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    cyc();
    FlagW = 2'b00;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'b0000; ALUFlags = 4'b1111; FlagW = 2'b11;
    PCS = 1'b1; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1;
    cyc();
    lit("reset_flags", Flags, 4'b0000);
    lit("reset_commits", {1'b0, PCWrite, RegWrite, MemWrite}, 4'b0000);

    reset = 1'b0; Cond = 4'b1110; FlagW = 2'b00;
    cyc();
    lit("post_reset_regwrite", {3'b000, RegWrite}, 4'b0001);

    RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
    set_flags(4'b0100);
    lit("flags_z", Flags, 4'b0100);
    Cond = 4'b0000; RegW = 1'b1;
    cyc();
    lit("eq_pass", {3'b000, RegWrite}, 4'b0001);
    Cond = 4'b0001;
    cyc();
    lit("ne_fail", {3'b000, RegWrite}, 4'b0000);

    set_flags(4'b1111);
    lit("flags_all", Flags, 4'b1111);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0000;
    cyc();
    lit("partial_nz", Flags, 4'b0011);
    FlagW = 2'b01; ALUFlags = 4'b1111;
    cyc();
    lit("partial_cv", Flags, 4'b0011);

    set_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NextPC = 1'b0;
    cyc();
    lit("fail_no_flag", Flags, 4'b0000);
    lit("fail_commits", {1'b0, PCWrite, RegWrite, MemWrite}, 4'b0000);
    FlagW = 2'b00; NextPC = 1'b1;
    #1;
    lit("nextpc_ungated", {3'b000, PCWrite}, 4'b0001);
    NextPC = 1'b0; PCS = 1'b0; MemW = 1'b0;

    set_flags(4'b1001);
    Cond = 4'b1010; cyc();
    lit("ge_nv", {3'b000, RegWrite}, 4'b0001);
    Cond = 4'b1011; cyc();
    lit("lt_nv", {3'b000, RegWrite}, 4'b0000);
    set_flags(4'b0100);
    Cond = 4'b1100; cyc();
    lit("gt_z", {3'b000, RegWrite}, 4'b0000);
    Cond = 4'b1101; cyc();
    lit("le_z", {3'b000, RegWrite}, 4'b0001);
    set_flags(4'b0010);
    Cond = 4'b1000; cyc();
    lit("hi_c", {3'b000, RegWrite}, 4'b0001);
    Cond = 4'b1001; cyc();
    lit("ls_c", {3'b000, RegWrite}, 4'b0000);

    RegW = 1'b0; PCS = 1'b1; NextPC = 1'b0;
    Cond = 4'b1111; cyc();
    lit("nv_pcwrite", {3'b000, PCWrite}, 4'b0000);

    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1'b1; reset = 1'b1;
    cyc();
    lit("reset_wins_flags", Flags, 4'b0000);
    lit("reset_wins_regw", {3'b000, RegWrite}, 4'b0000);
    reset = 1'b0; FlagW = 2'b00;

    MemW = 1'b1;
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        FlagW = 2'(c);
        ALUFlags = 4'(15 - f);
        cyc();
        set_flags(4'(f));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
